// File: rtl/mem_uart_if_pkg.sv
// -----------------------------------------------------------------------------
// text_pkg
//   Constants and types shared by the character-screen datapaths (the UART
//   write path and the mem_uart_if read-back path).
//   Contents:
//     COLS, ROWS        screen geometry (characters per row, rows per screen)
//     CR, LF, ESC, SPACE character codes used on the UART stream
//     state_t           read-back FSM states
//     byte_kind_t       what the byte currently in flight on TX represents
//     blank_to_space()  maps a cleared cell (0x00) to a printable space
// -----------------------------------------------------------------------------
package text_pkg;

   localparam int COLS = 80;
   localparam int ROWS = 40;

   localparam logic [7:0] CR    = 8'd13;
   localparam logic [7:0] LF    = 8'd10;
   localparam logic [7:0] ESC   = 8'd27;
   localparam logic [7:0] SPACE = 8'd32;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      SEND,
      WAIT_ACK,
      WAIT_DONE,
      EOL_CR,
      EOL_LF,
      FINISH
   } state_t;

   typedef enum logic [1:0] {
      KIND_CHAR,
      KIND_CR,
      KIND_LF
   } byte_kind_t;

   // A never-written cell reads as 0x00; show it on the terminal as a blank.
   function automatic logic [7:0] blank_to_space(input logic [7:0] c);
      return (c == 8'h00) ? SPACE : c;
   endfunction

endpackage

// File: rtl/mem_uart_if_if.sv
// -----------------------------------------------------------------------------
// mem_uart_bus
//   Bundles the dump request/status, the character-RAM read port and the UART
//   TX byte handshake used by mem_uart_if.
//   Signals:
//     start      dump request (sampled by the reader only when idle)
//     rdaddress  RAM read address            (reader -> RAM)
//     q          RAM read data, RD_LAT later (RAM -> reader)
//     tx_data    byte to transmit            (reader -> TX)
//     tx_start   one-cycle transmit strobe   (reader -> TX)
//     tx_busy    transmitter busy            (TX -> reader)
//     busy       dump in progress            (reader -> system)
//     done       one-cycle completion pulse  (reader -> system)
//   Modports:
//     master  the read-back engine (mem_uart_if)
//     slave   the surroundings: requester, RAM and transmitter
// -----------------------------------------------------------------------------
interface mem_uart_bus #(
   parameter int ADDR_W = 12
);

   logic              start;
   logic [ADDR_W-1:0] rdaddress;
   logic [7:0]        q;
   logic [7:0]        tx_data;
   logic              tx_start;
   logic              tx_busy;
   logic              busy;
   logic              done;

   modport master (
      input  start, q, tx_busy,
      output rdaddress, tx_data, tx_start, busy, done
   );

   modport slave (
      output start, q, tx_busy,
      input  rdaddress, tx_data, tx_start, busy, done
   );

endinterface

// File: rtl/mem_uart_if.sv
// -----------------------------------------------------------------------------
// mem_uart_if
//   Reads the COLS x ROWS character buffer in row-major order and streams it
//   to the UART transmitter, appending CR (and LF when EMIT_LF=1) after every
//   row, so a host terminal receives a copy of the screen.
//   Ports:
//     clock100  system clock (single domain)
//     reset     synchronous, active-high
//     bus       mem_uart_bus.master: start, rdaddress, q, tx_data, tx_start,
//               tx_busy, busy, done
//   Parameters:
//     COLS, ROWS  screen geometry
//     ADDR_W      RAM address width (COLS*ROWS-1 must fit)
//     RD_LAT      RAM read latency in cycles
//     EMIT_LF     1: end of line is CR LF, 0: CR only
// -----------------------------------------------------------------------------
module mem_uart_if #(
   parameter int COLS    = text_pkg::COLS,
   parameter int ROWS    = text_pkg::ROWS,
   parameter int ADDR_W  = 12,
   parameter int RD_LAT  = 2,
   parameter bit EMIT_LF = 1'b1
) (
   input  logic          clock100,
   input  logic          reset,
   mem_uart_bus.master   bus
);

   import text_pkg::*;

   localparam int COL_W = (COLS   > 1) ? $clog2(COLS)     : 1;
   localparam int ROW_W = (ROWS   > 1) ? $clog2(ROWS)     : 1;
   localparam int CNT_W = (RD_LAT > 0) ? $clog2(RD_LAT+1) : 1;

   localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
   localparam logic [CNT_W-1:0] LAT_CNT  = CNT_W'(RD_LAT);

   // Registered state
   state_t            state,     state_n;
   byte_kind_t        kind,      kind_n;
   logic [ROW_W-1:0]  row,       row_n;
   logic [COL_W-1:0]  col,       col_n;
   logic [ADDR_W-1:0] addr,      addr_n;
   logic [CNT_W-1:0]  lat_cnt,   lat_cnt_n;
   logic [7:0]        tx_data_r, tx_data_n;
   logic              busy_r,    busy_n;
   logic              done_r,    done_n;

   // Combinational helpers
   logic              tx_start_c;
   logic              end_of_row;

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clock100) begin
      if (reset) begin
         state     <= IDLE;
         kind      <= KIND_CHAR;
         row       <= '0;
         col       <= '0;
         addr      <= '0;
         lat_cnt   <= '0;
         tx_data_r <= '0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state     <= state_n;
         kind      <= kind_n;
         row       <= row_n;
         col       <= col_n;
         addr      <= addr_n;
         lat_cnt   <= lat_cnt_n;
         tx_data_r <= tx_data_n;
         busy_r    <= busy_n;
         done_r    <= done_n;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and output logic
   // ---------------------------------------------------------------------------
   // NOTE: every signal written here gets a default first, so no path through
   // the case statement leaves one unassigned and no latch is inferred.
   always_comb begin
      state_n    = state;
      kind_n     = kind;
      row_n      = row;
      col_n      = col;
      addr_n     = addr;
      lat_cnt_n  = lat_cnt;
      tx_data_n  = tx_data_r;
      busy_n     = busy_r;
      done_n     = 1'b0;
      tx_start_c = 1'b0;
      end_of_row = 1'b0;

      case (state)
         IDLE: begin
            if (bus.start) begin
               row_n     = '0;
               col_n     = '0;
               addr_n    = '0;
               lat_cnt_n = '0;
               busy_n    = 1'b1;
               state_n   = READ;
            end
         end

         // rdaddress follows addr, which is frozen here; the counter lets the
         // RAM pipeline fill before q is taken.
         READ: begin
            if (lat_cnt == LAT_CNT) begin
               tx_data_n = blank_to_space(bus.q);
               kind_n    = KIND_CHAR;
               lat_cnt_n = '0;
               state_n   = SEND;
            end else begin
               lat_cnt_n = lat_cnt + 1'b1;
            end
         end

         // The strobe is gated by tx_busy so it can never fire into a busy
         // transmitter; leaving SEND at once keeps it a single-cycle pulse.
         SEND: begin
            if (!bus.tx_busy) begin
               tx_start_c = 1'b1;
               state_n    = WAIT_ACK;
            end
         end

         WAIT_ACK: begin
            if (bus.tx_busy) begin
               state_n = WAIT_DONE;
            end
         end

         WAIT_DONE: begin
            if (!bus.tx_busy) begin
               case (kind)
                  KIND_CHAR: begin
                     if (col != LAST_COL) begin
                        col_n   = col + 1'b1;
                        addr_n  = addr + 1'b1;
                        state_n = READ;
                     end else begin
                        state_n = EOL_CR;
                     end
                  end
                  KIND_CR: begin
                     if (EMIT_LF) begin
                        state_n = EOL_LF;
                     end else begin
                        end_of_row = 1'b1;
                     end
                  end
                  default: begin
                     end_of_row = 1'b1;
                  end
               endcase

               // addr advances across the row boundary exactly like within a
               // row, so it stays equal to COLS*row+col without a multiplier.
               if (end_of_row) begin
                  if (row != LAST_ROW) begin
                     row_n   = row + 1'b1;
                     col_n   = '0;
                     addr_n  = addr + 1'b1;
                     state_n = READ;
                  end else begin
                     busy_n  = 1'b0;
                     done_n  = 1'b1;
                     state_n = FINISH;
                  end
               end
            end
         end

         EOL_CR: begin
            tx_data_n = CR;
            kind_n    = KIND_CR;
            state_n   = SEND;
         end

         EOL_LF: begin
            tx_data_n = LF;
            kind_n    = KIND_LF;
            state_n   = SEND;
         end

         // done_r is high for exactly this cycle; busy_r already dropped.
         FINISH: begin
            state_n = IDLE;
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.rdaddress = addr;
   assign bus.tx_data   = tx_data_r;
   assign bus.tx_start  = tx_start_c;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;

endmodule
